// File: rtl/pl_hazard_ctrl.sv
// pl_hazard_ctrl: load-use stall, redirect flush, dmem freeze and EX forwarding
// control for a 5-stage pipeline. Rev 1.0
`default_nettype none

module pl_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             ex_redirect,
  input  logic             mem_ready,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_ifid,
  output logic             bubble_idex,
  output logic             hold_exmem,
  output logic             bubble_memwb,
  output logic             pc_redirect,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
  } stage_t;

  localparam stage_t c_bubble = '0;

  stage_t           r_ex, r_mem, w_id;
  logic [4:0]       r_ex_rs1, r_ex_rs2;
  logic             r_wb_valid, r_wb_regwrite;
  logic [4:0]       r_wb_rd;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_freeze, w_redirect, w_loaduse, w_kill_id;
  logic w_rs1_hit, w_rs2_hit;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_id = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite,
                  memread: id_memread, memwrite: id_memwrite};

  assign w_freeze   = r_mem.valid & (r_mem.memread | r_mem.memwrite) & ~mem_ready;
  assign w_redirect = r_ex.valid & ex_redirect & ~w_freeze;

  assign w_rs1_hit = id_use_rs1 & (id_rs1 == r_ex.rd);
  assign w_rs2_hit = id_use_rs2 & (id_rs2 == r_ex.rd);
  assign w_loaduse = id_valid & r_ex.valid & r_ex.memread & (r_ex.rd != 5'd0) &
                     (w_rs1_hit | w_rs2_hit) & ~w_freeze & ~w_redirect;

  assign w_kill_id = w_redirect | w_loaduse;

  // Loads still in MEM have no data yet, so only non-load MEM results forward.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input stage_t     mem,
    input logic       wb_valid,
    input logic       wb_regwrite,
    input logic [4:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (mem.valid && mem.regwrite && !mem.memread && mem.rd != 5'd0 && mem.rd == src)
      sel = 2'b10;
    else if (wb_valid && wb_regwrite && wb_rd != 5'd0 && wb_rd == src)
      sel = 2'b01;
    return sel;
  endfunction

  assign w_fwd_a = fwd_sel(r_ex_rs1, r_mem, r_wb_valid, r_wb_regwrite, r_wb_rd);
  assign w_fwd_b = fwd_sel(r_ex_rs2, r_mem, r_wb_valid, r_wb_regwrite, r_wb_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex          <= c_bubble;
      r_ex_rs1      <= 5'd0;
      r_ex_rs2      <= 5'd0;
      r_mem         <= c_bubble;
      r_wb_valid    <= 1'b0;
      r_wb_rd       <= 5'd0;
      r_wb_regwrite <= 1'b0;
    end else if (w_freeze) begin
      r_wb_valid    <= 1'b0;
      r_wb_rd       <= 5'd0;
      r_wb_regwrite <= 1'b0;
    end else begin
      r_wb_valid    <= r_mem.valid;
      r_wb_rd       <= r_mem.rd;
      r_wb_regwrite <= r_mem.regwrite;
      r_mem         <= r_ex;
      r_ex          <= w_kill_id ? c_bubble : w_id;
      r_ex_rs1      <= w_kill_id ? 5'd0 : id_rs1;
      r_ex_rs2      <= w_kill_id ? 5'd0 : id_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_freeze | w_loaduse) && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_redirect && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // Outputs are forced quiet while reset is asserted, even mid-freeze.
  assign stall_pc     = ~rst & (w_freeze | w_loaduse);
  assign stall_ifid   = ~rst & (w_freeze | w_loaduse);
  assign bubble_ifid  = ~rst & w_redirect;
  assign bubble_idex  = ~rst & w_kill_id;
  assign hold_exmem   = ~rst & w_freeze;
  assign bubble_memwb = ~rst & w_freeze;
  assign pc_redirect  = ~rst & w_redirect;
  assign fwd_a        = rst ? 2'b00 : w_fwd_a;
  assign fwd_b        = rst ? 2'b00 : w_fwd_b;
  assign stall_cnt    = rst ? '0 : r_stall_cnt;
  assign flush_cnt    = rst ? '0 : r_flush_cnt;

endmodule

`default_nettype wire
